// File: rtl/width_12to8_pkg.sv
// Shared widths for the 12-bit to 8-bit packet width converter.
package width_12to8_pkg;
   localparam int W_IN   = 12;
   localparam int W_OUT  = 8;
   localparam int BUF_W  = 24;
   // Fill counts 0..BUF_W bits inclusive.
   localparam int FILL_W = $clog2(BUF_W + 1);
endpackage

// File: rtl/width_12to8.sv
// Repacks a stream of 12-bit words into bytes, MSB first, padding an odd
// trailing nibble with zeros at packet end and flagging the final byte.
module width_12to8
   import width_12to8_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   output logic              ready_in,
   input  logic [W_IN-1:0]   data_in,
   input  logic              last_in,
   output logic              valid_out,
   input  logic              ready_out,
   output logic [W_OUT-1:0]  data_out,
   output logic              last_out
);

   // Handshake: a word moves on valid_in && ready_in, a byte on
   // valid_out && ready_out; the producer holds its payload until taken.

   localparam logic [FILL_W-1:0] OUT_BITS    = FILL_W'(W_OUT);
   localparam logic [FILL_W-1:0] IN_BITS     = FILL_W'(W_IN);
   localparam logic [FILL_W-1:0] PAD_BITS    = FILL_W'(4);
   localparam logic [FILL_W-1:0] MAX_IN_FILL = FILL_W'(BUF_W - W_IN);

   logic [BUF_W-1:0]  buf_q;
   logic [BUF_W-1:0]  buf_shift;
   logic [BUF_W-1:0]  buf_nxt;
   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] fill_shift;
   logic [FILL_W-1:0] fill_push;
   logic [FILL_W-1:0] fill_nxt;
   logic              last_pend_q;
   logic              push;
   logic              pop;

   assign valid_out = (fill_q >= OUT_BITS);
   assign data_out  = buf_q[BUF_W-1 -: W_OUT];
   assign last_out  = valid_out && last_pend_q && (fill_q == OUT_BITS);
   assign ready_in  = (fill_q <= MAX_IN_FILL) && !last_pend_q && !rst;

   assign push = valid_in && ready_in;
   assign pop  = valid_out && ready_out;

   // Bits below the fill point are always zero, so a push can simply OR
   // the word in and end-of-packet padding is just a fill bump.
   always_comb begin
      buf_shift  = buf_q;
      fill_shift = fill_q;
      if (pop) begin
         buf_shift  = buf_q << W_OUT;
         fill_shift = fill_q - OUT_BITS;
      end
      fill_push = fill_shift + IN_BITS;
      buf_nxt   = buf_shift;
      fill_nxt  = fill_shift;
      if (push) begin
         buf_nxt  = buf_shift | ({data_in, {(BUF_W - W_IN){1'b0}}} >> fill_shift);
         fill_nxt = fill_push;
         if (last_in && (fill_push[2:0] != 3'd0)) begin
            fill_nxt = fill_push + PAD_BITS;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q  <= '0;
         fill_q <= '0;
      end else begin
         buf_q  <= buf_nxt;
         fill_q <= fill_nxt;
      end
   end

   // A pending last blocks further input until its final byte leaves.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_pend_q <= 1'b0;
      end else if (push && last_in) begin
         last_pend_q <= 1'b1;
      end else if (pop && last_out) begin
         last_pend_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_width_12to8.sv
// Bench for width_12to8: directed scenarios plus random traffic, checked by a
// nibble-queue reference model feeding an expected-byte scoreboard.
module tb_width_12to8;
   import width_12to8_pkg::*;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        valid_in  = 1'b0;
   logic        ready_in;
   logic [11:0] data_in   = '0;
   logic        last_in   = 1'b0;
   logic        valid_out;
   logic        ready_out = 1'b0;
   logic [7:0]  data_out;
   logic        last_out;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;
   int rdy_mode = 1;          // 0: ready_out high, 1: low, 2: random

   logic [8:0] exp_q[$];      // {last, byte}
   logic [8:0] got_q[$];
   logic [3:0] nib_q[$];
   bit         model_last_pend = 1'b0;

   logic       hold      = 1'b0;
   logic [7:0] hold_data = '0;
   logic       hold_last = 1'b0;
   logic [8:0] exp_e;

   width_12to8 dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .data_in   (data_in),
      .last_in   (last_in),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .data_out  (data_out),
      .last_out  (last_out)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: a packet is a nibble stream; bytes are nibble pairs, an odd
   // final nibble is completed with zero, the final byte carries last.
   function automatic void model_push(input logic [11:0] w, input bit last);
      logic [3:0] hi;
      logic [3:0] lo;
      nib_q.push_back(w[11:8]);
      nib_q.push_back(w[7:4]);
      nib_q.push_back(w[3:0]);
      if (last && (nib_q.size() % 2 == 1)) nib_q.push_back(4'h0);
      while (nib_q.size() >= 2) begin
         hi = nib_q.pop_front();
         lo = nib_q.pop_front();
         exp_q.push_back({last && (nib_q.size() == 0), hi, lo});
      end
      if (last) model_last_pend = 1'b1;
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      nib_q.delete();
      model_last_pend = 1'b0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_word(input logic [11:0] w, input bit last);
      int  waited = 0;
      bit  done   = 1'b0;
      @(posedge clk); #1;
      valid_in = 1'b1;
      data_in  = w;
      last_in  = last;
      while (!done) begin
         @(negedge clk); #1;
         if (ready_in) begin
            model_push(w, last);
            done = 1'b1;
         end else if (waited > 300) begin
            check("push_accept_timeout", ready_in, 1);
            done = 1'b1;
         end else begin
            waited++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         valid_in = 1'b0;
         last_in  = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic drain();
      int t = 0;
      idle(1);
      rdy_mode = 0;
      while (exp_q.size() > 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("drain_empty", exp_q.size(), 0);
      idle(2);
      check("idle_valid_out", valid_out, 0);
   endtask

   task automatic reset_pulse();
      @(posedge clk); #1;
      rst      = 1'b1;
      valid_in = 1'b0;
      last_in  = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready_in", ready_in, 1);
      check("rst_valid_out", valid_out, 0);
      check("rst_data_out", data_out, 8'h00);
      check("rst_last_out", last_out, 0);
   endtask

   // ---------------- downstream ready ----------------
   initial forever begin
      @(posedge clk); #1;
      case (rdy_mode)
         0:       ready_out = 1'b1;
         1:       ready_out = 1'b0;
         default: ready_out = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- monitor / scoreboard ----------------
   initial forever begin
      @(negedge clk);
      if (rst) begin
         hold = 1'b0;
      end else begin
         check("fill_le_24", 32'(dut.fill_q <= 5'd24), 1);
         if (model_last_pend) check("ready_in_while_last", ready_in, 0);
         if (hold) begin
            check("hold_valid", valid_out, 1);
            check("hold_data", data_out, hold_data);
            check("hold_last", last_out, hold_last);
         end
         if (valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got last=%0b data=0x%0h, expected no byte at %0t",
                        last_out, data_out, $time);
            end else begin
               exp_e = exp_q.pop_front();
               check("byte", {last_out, data_out}, exp_e);
               if (exp_e[8]) model_last_pend = 1'b0;
            end
            got_q.push_back({last_out, data_out});
            n_pops++;
         end
         hold      = valid_out && !ready_out;
         hold_data = data_out;
         hold_last = last_out;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      int p0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("init_ready_in", ready_in, 1);
      check("init_valid_out", valid_out, 0);
      check("init_data_out", data_out, 8'h00);
      check("init_last_out", last_out, 0);

      // Two words, free-flowing output.
      rdy_mode = 0;
      got_q.delete();
      send_word(12'hABC, 1'b0);
      send_word(12'hDEF, 1'b0);
      drain();
      check("abc_def_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("abc_def_b0", got_q[0], 9'h0AB);
         check("abc_def_b1", got_q[1], 9'h0CD);
         check("abc_def_b2", got_q[2], 9'h0EF);
      end

      // Single-word packet with padding; input blocked until last pops.
      rdy_mode = 1;
      got_q.delete();
      send_word(12'h123, 1'b1);
      idle(1);
      repeat (2) begin
         @(negedge clk);
         check("last_pend_ready_in", ready_in, 0);
         check("last_pend_first_data", data_out, 8'h12);
         check("last_pend_first_last", last_out, 0);
      end
      drain();
      check("w123_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("w123_b0", got_q[0], 9'h012);
         check("w123_b1", got_q[1], 9'h130);
      end
      check("w123_ready_after", ready_in, 1);

      // Backpressure fills the buffer; nothing lost after release.
      rdy_mode = 1;
      got_q.delete();
      send_word(12'h9E1, 1'b0);
      send_word(12'h47B, 1'b0);
      @(posedge clk); #1;
      valid_in = 1'b1;
      data_in  = 12'hC2D;
      last_in  = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("bp_ready_in", ready_in, 0);
         check("bp_valid_out", valid_out, 1);
         check("bp_data_out", data_out, 8'h9E);
         check("bp_fill", dut.fill_q, 24);
      end
      rdy_mode = 0;
      send_word(12'hC2D, 1'b0);
      send_word(12'h60F, 1'b1);
      drain();
      check("bp_count", got_q.size(), 6);
      if (got_q.size() == 6) begin
         check("bp_b0", got_q[0], 9'h09E);
         check("bp_b1", got_q[1], 9'h014);
         check("bp_b2", got_q[2], 9'h07B);
         check("bp_b3", got_q[3], 9'h0C2);
         check("bp_b4", got_q[4], 9'h0D6);
         check("bp_b5", got_q[5], 9'h10F);
      end

      // Twelve back-to-back words give exactly eighteen bytes.
      rdy_mode = 0;
      p0 = n_pops;
      for (int i = 0; i < 12; i++) send_word(12'($urandom_range(0, 4095)), 1'b0);
      drain();
      check("stream_byte_count", n_pops - p0, 18);

      // Reset mid-packet discards buffered bits.
      rdy_mode = 1;
      send_word(12'hFFF, 1'b0);
      idle(1);
      reset_pulse();
      got_q.delete();
      rdy_mode = 0;
      send_word(12'h5A5, 1'b1);
      drain();
      check("post_rst_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("post_rst_b0", got_q[0], 9'h05A);
         check("post_rst_b1", got_q[1], 9'h150);
      end

      // Simultaneous push and pop at fill 12.
      rdy_mode = 1;
      got_q.delete();
      send_word(12'h321, 1'b0);
      idle(1);
      check("pp_fill_before", dut.fill_q, 12);
      rdy_mode = 0;
      send_word(12'h654, 1'b0);
      @(negedge clk);
      check("pp_fill_after", dut.fill_q, 16);
      send_word(12'h987, 1'b1);
      drain();
      check("pp_count", got_q.size(), 5);
      if (got_q.size() == 5) begin
         check("pp_b0", got_q[0], 9'h032);
         check("pp_b1", got_q[1], 9'h016);
         check("pp_b2", got_q[2], 9'h054);
         check("pp_b3", got_q[3], 9'h098);
         check("pp_b4", got_q[4], 9'h170);
      end

      // Random traffic with random backpressure and occasional resets.
      rdy_mode = 2;
      for (int i = 0; i < 80; i++) begin
         send_word(12'($urandom_range(0, 4095)), ($urandom_range(0, 5) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         if ($urandom_range(0, 24) == 0) begin
            reset_pulse();
            rdy_mode = 2;
         end
      end
      send_word(12'($urandom_range(0, 4095)), 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
